// File: rtl/credential_checker.sv
// ============================================================================
//  Module      : credential_checker
//  Description : Username/password entry and unlock controller with failure
//                counting, tick-timed lockout and idle-entry timeout.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module credential_checker #(
    parameter int DIGIT_W       = 4,
    parameter int CODE_LEN      = 4,
    parameter int NUM_USERS     = 2,
    parameter int MAX_FAILS     = 3,
    parameter int LOCKOUT_TICKS = 30,
    parameter int ENTRY_TIMEOUT = 10
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      i_tick,
    input  logic                                      i_digit_valid,
    input  logic [DIGIT_W-1:0]                        i_digit,
    input  logic                                      i_enter,
    input  logic                                      i_clear,
    input  logic                                      i_lock_req,
    input  logic                                      i_mode,
    input  logic [NUM_USERS*CODE_LEN*DIGIT_W-1:0]     i_user_names,
    input  logic [NUM_USERS*CODE_LEN*DIGIT_W-1:0]     i_user_pwds,
    input  logic [CODE_LEN*DIGIT_W-1:0]               i_guest_pwd,
    output logic                                      o_unlocked,
    output logic                                      o_fail_pulse,
    output logic                                      o_locked_out,
    output logic [1:0]                                o_stage,
    output logic [CODE_LEN*DIGIT_W-1:0]               o_entry_digits,
    output logic [$clog2(CODE_LEN+1)-1:0]             o_entry_count,
    output logic [$clog2(MAX_FAILS+1)-1:0]            o_fail_count,
    output logic [$clog2(LOCKOUT_TICKS+1)-1:0]        o_lockout_left,
    output logic [(NUM_USERS > 1 ? $clog2(NUM_USERS) : 1)-1:0] o_matched_user
);

    localparam int c_CW    = CODE_LEN * DIGIT_W;
    localparam int c_CNT_W = $clog2(CODE_LEN + 1);
    localparam int c_FC_W  = $clog2(MAX_FAILS + 1);
    localparam int c_LO_W  = $clog2(LOCKOUT_TICKS + 1);
    localparam int c_TO_W  = $clog2(ENTRY_TIMEOUT + 1);
    localparam int c_MU_W  = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ENTER_USER = 3'd1,
        S_ENTER_PWD  = 3'd2,
        S_CHECK      = 3'd3,
        S_UNLOCKED   = 3'd4,
        S_LOCKOUT    = 3'd5
    } state_t;

    state_t              r_state;
    logic                r_mode;
    logic [c_CW-1:0]     r_buf;
    logic [c_CNT_W-1:0]  r_count;
    logic [c_TO_W-1:0]   r_timeout;
    logic                r_user_hit;
    logic [c_MU_W-1:0]   r_user_idx;
    logic [c_FC_W-1:0]   r_fail_count;
    logic [c_LO_W-1:0]   r_lockout_left;
    logic [c_MU_W-1:0]   r_matched;
    logic [1:0]          r_stage;
    logic                r_unlocked;
    logic                r_fail_pulse;
    logic                r_locked_out;

    logic                w_name_hit;
    logic [c_MU_W-1:0]   w_name_idx;
    logic [c_CW-1:0]     w_user_pwd;
    logic                w_pass;
    logic                w_digit_ok;

    // Descending scan so the lowest matching index is the one that sticks.
    always_comb begin
        w_name_hit = 1'b0;
        w_name_idx = '0;
        w_user_pwd = '0;
        for (int u = NUM_USERS - 1; u >= 0; u--) begin
            if (i_user_names[u*c_CW +: c_CW] == r_buf) begin
                w_name_hit = 1'b1;
                w_name_idx = c_MU_W'(u);
            end
            if (c_MU_W'(u) == r_user_idx) begin
                w_user_pwd = i_user_pwds[u*c_CW +: c_CW];
            end
        end
    end

    assign w_pass = (r_count == c_CNT_W'(CODE_LEN)) &&
                    (r_mode ? (r_user_hit && (r_buf == w_user_pwd))
                            : (r_buf == i_guest_pwd));

    assign w_digit_ok = i_digit_valid && (r_count < c_CNT_W'(CODE_LEN));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_mode         <= 1'b0;
            r_buf          <= '0;
            r_count        <= '0;
            r_timeout      <= '0;
            r_user_hit     <= 1'b0;
            r_user_idx     <= '0;
            r_fail_count   <= '0;
            r_lockout_left <= '0;
            r_matched      <= '0;
            r_stage        <= 2'd0;
            r_unlocked     <= 1'b0;
            r_fail_pulse   <= 1'b0;
            r_locked_out   <= 1'b0;
        end else begin
            r_fail_pulse <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_digit_valid && !i_clear && !i_enter) begin
                        r_buf      <= c_CW'(i_digit);
                        r_count    <= c_CNT_W'(1);
                        r_timeout  <= c_TO_W'(ENTRY_TIMEOUT);
                        r_mode     <= i_mode;
                        r_user_hit <= 1'b0;
                        r_user_idx <= '0;
                        r_state    <= i_mode ? S_ENTER_USER : S_ENTER_PWD;
                        r_stage    <= i_mode ? 2'd1 : 2'd2;
                    end
                end
                S_ENTER_USER, S_ENTER_PWD: begin
                    if (i_clear) begin
                        r_buf     <= '0;
                        r_count   <= '0;
                        r_timeout <= '0;
                        r_state   <= S_IDLE;
                        r_stage   <= 2'd0;
                    end else if (i_enter) begin
                        if (r_state == S_ENTER_USER) begin
                            r_user_hit <= w_name_hit;
                            r_user_idx <= w_name_idx;
                            r_buf      <= '0;
                            r_count    <= '0;
                            r_timeout  <= c_TO_W'(ENTRY_TIMEOUT);
                            r_state    <= S_ENTER_PWD;
                            r_stage    <= 2'd2;
                        end else begin
                            r_state <= S_CHECK;
                        end
                    end else if (w_digit_ok) begin
                        r_buf     <= (r_buf << DIGIT_W) | c_CW'(i_digit);
                        r_count   <= r_count + c_CNT_W'(1);
                        r_timeout <= c_TO_W'(ENTRY_TIMEOUT);
                    end else if (i_tick) begin
                        if (r_timeout <= c_TO_W'(1)) begin
                            r_buf     <= '0;
                            r_count   <= '0;
                            r_timeout <= '0;
                            r_state   <= S_IDLE;
                            r_stage   <= 2'd0;
                        end else begin
                            r_timeout <= r_timeout - c_TO_W'(1);
                        end
                    end
                end
                S_CHECK: begin
                    r_buf     <= '0;
                    r_count   <= '0;
                    r_timeout <= '0;
                    if (w_pass) begin
                        r_unlocked   <= 1'b1;
                        r_matched    <= r_mode ? r_user_idx : '0;
                        r_fail_count <= '0;
                        r_state      <= S_UNLOCKED;
                        r_stage      <= 2'd3;
                    end else begin
                        r_fail_pulse <= 1'b1;
                        if (r_fail_count >= c_FC_W'(MAX_FAILS - 1)) begin
                            r_fail_count   <= c_FC_W'(MAX_FAILS);
                            r_locked_out   <= 1'b1;
                            r_lockout_left <= c_LO_W'(LOCKOUT_TICKS);
                            r_state        <= S_LOCKOUT;
                            r_stage        <= 2'd3;
                        end else begin
                            r_fail_count <= r_fail_count + c_FC_W'(1);
                            r_state      <= S_IDLE;
                            r_stage      <= 2'd0;
                        end
                    end
                end
                S_UNLOCKED: begin
                    if (i_lock_req) begin
                        r_unlocked <= 1'b0;
                        r_matched  <= '0;
                        r_state    <= S_IDLE;
                        r_stage    <= 2'd0;
                    end
                end
                S_LOCKOUT: begin
                    if (i_tick) begin
                        if (r_lockout_left <= c_LO_W'(1)) begin
                            r_lockout_left <= '0;
                            r_locked_out   <= 1'b0;
                            r_fail_count   <= '0;
                            r_state        <= S_IDLE;
                            r_stage        <= 2'd0;
                        end else begin
                            r_lockout_left <= r_lockout_left - c_LO_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_stage <= 2'd0;
                end
            endcase
        end
    end

    assign o_unlocked     = r_unlocked;
    assign o_fail_pulse   = r_fail_pulse;
    assign o_locked_out   = r_locked_out;
    assign o_stage        = r_stage;
    assign o_entry_digits = r_buf;
    assign o_entry_count  = r_count;
    assign o_fail_count   = r_fail_count;
    assign o_lockout_left = r_lockout_left;
    assign o_matched_user = r_matched;

endmodule

`default_nettype wire

// File: tb/tb_credential_checker.sv
// ============================================================================
//  Module      : tb_credential_checker
//  Description : Directed self-checking bench for credential_checker.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_credential_checker;

    logic        clk;
    logic        rst;
    logic        i_tick;
    logic        i_digit_valid;
    logic [3:0]  i_digit;
    logic        i_enter;
    logic        i_clear;
    logic        i_lock_req;
    logic        i_mode;
    logic [31:0] i_user_names;
    logic [31:0] i_user_pwds;
    logic [15:0] i_guest_pwd;
    logic        o_unlocked;
    logic        o_fail_pulse;
    logic        o_locked_out;
    logic [1:0]  o_stage;
    logic [15:0] o_entry_digits;
    logic [2:0]  o_entry_count;
    logic [1:0]  o_fail_count;
    logic [4:0]  o_lockout_left;
    logic [0:0]  o_matched_user;

    int n_cmp = 0;
    int n_err = 0;

    credential_checker dut (
        .clk            (clk),
        .rst            (rst),
        .i_tick         (i_tick),
        .i_digit_valid  (i_digit_valid),
        .i_digit        (i_digit),
        .i_enter        (i_enter),
        .i_clear        (i_clear),
        .i_lock_req     (i_lock_req),
        .i_mode         (i_mode),
        .i_user_names   (i_user_names),
        .i_user_pwds    (i_user_pwds),
        .i_guest_pwd    (i_guest_pwd),
        .o_unlocked     (o_unlocked),
        .o_fail_pulse   (o_fail_pulse),
        .o_locked_out   (o_locked_out),
        .o_stage        (o_stage),
        .o_entry_digits (o_entry_digits),
        .o_entry_count  (o_entry_count),
        .o_fail_count   (o_fail_count),
        .o_lockout_left (o_lockout_left),
        .o_matched_user (o_matched_user)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put_digit(input logic [3:0] d);
        i_digit = d;
        i_digit_valid = 1'b1;
        step();
        i_digit_valid = 1'b0;
    endtask

    task automatic put_code(input logic [15:0] code);
        for (int i = 3; i >= 0; i--) put_digit(code[i*4 +: 4]);
    endtask

    // Leaves the bench sampling in cycle N+2 after the enter strobe.
    task automatic submit();
        i_enter = 1'b1;
        step();
        i_enter = 1'b0;
        step();
    endtask

    task automatic put_tick();
        i_tick = 1'b1;
        step();
        i_tick = 1'b0;
    endtask

    task automatic put_clear();
        i_clear = 1'b1;
        step();
        i_clear = 1'b0;
    endtask

    task automatic put_lock();
        i_lock_req = 1'b1;
        step();
        i_lock_req = 1'b0;
    endtask

    task automatic wrong_guest(input logic [1:0] exp_fc);
        put_code(16'h9999);
        submit();
        chk("wrong_guest_pulse", 32'(o_fail_pulse), 32'd1);
        chk("wrong_guest_fc", 32'(o_fail_count), 32'(exp_fc));
    endtask

    initial begin
        rst = 1'b1;
        i_tick = 1'b0; i_digit_valid = 1'b0; i_digit = 4'd0;
        i_enter = 1'b0; i_clear = 1'b0; i_lock_req = 1'b0; i_mode = 1'b0;
        i_user_names = {16'h1111, 16'h5678};
        i_user_pwds  = {16'h4321, 16'h9999};
        i_guest_pwd  = 16'h1234;
        step(); step();
        chk("rst_stage", 32'(o_stage), 32'd0);
        chk("rst_unlocked", 32'(o_unlocked), 32'd0);
        chk("rst_buf", 32'(o_entry_digits), 32'd0);
        rst = 1'b0;
        step();

        // Guest unlock
        put_digit(4'd1);
        chk("guest_stage_pwd", 32'(o_stage), 32'd2);
        put_digit(4'd2); put_digit(4'd3); put_digit(4'd4);
        chk("guest_buf", 32'(o_entry_digits), 32'h1234);
        chk("guest_count", 32'(o_entry_count), 32'd4);
        i_enter = 1'b1; step(); i_enter = 1'b0;
        chk("guest_n1_not_yet", 32'(o_unlocked), 32'd0);
        step();
        chk("guest_unlocked", 32'(o_unlocked), 32'd1);
        chk("guest_matched", 32'(o_matched_user), 32'd0);
        chk("guest_stage3", 32'(o_stage), 32'd3);
        put_digit(4'd7);
        chk("unlocked_ignores_digit", 32'(o_entry_count), 32'd0);
        put_lock();
        chk("guest_relock", 32'(o_unlocked), 32'd0);

        // User 1 unlock
        i_mode = 1'b1;
        put_code(16'h1111);
        chk("user_stage1", 32'(o_stage), 32'd1);
        i_mode = 1'b0;
        i_enter = 1'b1; step(); i_enter = 1'b0;
        chk("user_stage2", 32'(o_stage), 32'd2);
        chk("user_count0", 32'(o_entry_count), 32'd0);
        put_code(16'h4321);
        submit();
        chk("user_unlocked", 32'(o_unlocked), 32'd1);
        chk("user_matched", 32'(o_matched_user), 32'd1);
        put_lock();
        chk("user_relock_unl", 32'(o_unlocked), 32'd0);
        chk("user_relock_stage", 32'(o_stage), 32'd0);
        chk("user_relock_mu", 32'(o_matched_user), 32'd0);

        // Overflow, clear, short entry
        put_code(16'h1234);
        put_digit(4'd5);
        chk("ovf_count", 32'(o_entry_count), 32'd4);
        chk("ovf_buf", 32'(o_entry_digits), 32'h1234);
        put_clear();
        chk("clr_stage", 32'(o_stage), 32'd0);
        chk("clr_buf", 32'(o_entry_digits), 32'd0);
        put_digit(4'd1); put_digit(4'd2); put_digit(4'd3);
        submit();
        chk("short_pulse", 32'(o_fail_pulse), 32'd1);
        chk("short_fc", 32'(o_fail_count), 32'd1);
        step();
        chk("short_pulse_one_cycle", 32'(o_fail_pulse), 32'd0);

        // Clear and timeout keep fail_count
        put_digit(4'd1); put_digit(4'd2);
        put_clear();
        chk("clr2_stage", 32'(o_stage), 32'd0);
        chk("clr2_fc", 32'(o_fail_count), 32'd1);
        put_digit(4'd1); put_digit(4'd2);
        for (int i = 0; i < 9; i++) put_tick();
        chk("to_pending", 32'(o_stage), 32'd2);
        put_tick();
        chk("to_idle", 32'(o_stage), 32'd0);
        chk("to_no_pulse", 32'(o_fail_pulse), 32'd0);
        chk("to_fc", 32'(o_fail_count), 32'd1);

        // Name of user 0 with password of user 1 must fail
        i_mode = 1'b1;
        put_code(16'h5678);
        i_enter = 1'b1; step(); i_enter = 1'b0;
        put_code(16'h4321);
        submit();
        chk("cross_pulse", 32'(o_fail_pulse), 32'd1);
        chk("cross_unl", 32'(o_unlocked), 32'd0);
        chk("cross_fc", 32'(o_fail_count), 32'd2);
        i_mode = 1'b0;

        // Good guest clears the failure count
        put_code(16'h1234);
        submit();
        chk("reset_fc_pass", 32'(o_fail_count), 32'd0);
        put_lock();

        // Lockout
        wrong_guest(2'd1);
        wrong_guest(2'd2);
        wrong_guest(2'd3);
        chk("lo_locked", 32'(o_locked_out), 32'd1);
        chk("lo_left", 32'(o_lockout_left), 32'd30);
        chk("lo_stage", 32'(o_stage), 32'd3);
        put_digit(4'd1);
        put_clear();
        chk("lo_digit_ignored", 32'(o_entry_count), 32'd0);
        for (int i = 0; i < 29; i++) put_tick();
        chk("lo_left_1", 32'(o_lockout_left), 32'd1);
        chk("lo_still_locked", 32'(o_locked_out), 32'd1);
        put_tick();
        chk("lo_released", 32'(o_locked_out), 32'd0);
        chk("lo_fc_cleared", 32'(o_fail_count), 32'd0);
        chk("lo_stage_idle", 32'(o_stage), 32'd0);

        // Asynchronous reset mid-lockout
        wrong_guest(2'd1);
        wrong_guest(2'd2);
        wrong_guest(2'd3);
        for (int i = 0; i < 13; i++) put_tick();
        chk("lo2_left17", 32'(o_lockout_left), 32'd17);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_locked", 32'(o_locked_out), 32'd0);
        chk("arst_left", 32'(o_lockout_left), 32'd0);
        chk("arst_fc", 32'(o_fail_count), 32'd0);
        chk("arst_stage", 32'(o_stage), 32'd0);
        step();
        rst = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
